// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder accumulator: controller state encoding
// and default datapath widths.
package adder_acc_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : adder_acc_pkg

// File: rtl/adder_acc_if.sv
// Operand stream (in_*) and result stream (out_*) handshakes of the
// adder accumulator. The slave modport is the accumulator side; the master
// modport is the source/consumer side.
interface adder_acc_if #(
    parameter int WIDTH       = adder_acc_pkg::DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = adder_acc_pkg::DEFAULT_COUNT_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_sum;
    logic [COUNT_WIDTH-1:0] out_carries;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carries
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carries
    );
endinterface : adder_acc_if

// File: rtl/adder_acc_ctrl.sv
// Run controller for the adder accumulator: sequencing FSM plus the
// down-counter of operands still expected in the current run.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; length is latched into remaining
//   ST_ACCUM | accepting operands; leaves after the beat with remaining==1
//   ST_DONE  | result presented downstream until out_ready
//
// All handshake outputs decode from the state register only, so in_ready
// and out_valid can never be high together.
module adder_acc_ctrl
    import adder_acc_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic                   in_valid,
    input  logic                   out_ready,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   load,
    output logic                   accept
);

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0] remaining_nxt;

    // State register and remaining-operand counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state decode, counter update and strobes.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        load          = 1'b0;
        accept        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load          = 1'b1;
                    remaining_nxt = length;
                    state_nxt     = (length == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    accept        = 1'b1;
                    remaining_nxt = remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : adder_acc_ctrl

// File: rtl/adder_accumulator.sv
// Accumulation controller around an external combinational adder. The
// adder sits in the feedback loop: add_a is the running sum, add_b the
// incoming operand, and the adder result is captured on every accepted beat.
// Optional build macro ADDACC_SATURATE_EN clamps the sum at all ones on a
// carry instead of wrapping; carry beats are counted either way.
module adder_accumulator
    import adder_acc_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_result,
    input  logic                   add_cout,
    output logic                   busy,
    adder_acc_if.slave             bus
);

    logic                   in_ready;
    logic                   out_valid;
    logic                   load;
    logic                   accept;
    logic [WIDTH-1:0]       acc;
    logic [WIDTH-1:0]       acc_nxt_sum;
    logic [COUNT_WIDTH-1:0] carries;

    adder_acc_ctrl #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .length    (length),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .load      (load),
        .accept    (accept)
    );

    // Value captured into the accumulator on an accepted beat.
    always_comb begin
`ifdef ADDACC_SATURATE_EN
        acc_nxt_sum = add_cout ? {WIDTH{1'b1}} : add_result;
`else
        acc_nxt_sum = add_result;
`endif
    end

    // Running sum and carry count; cleared when a run is started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            carries <= '0;
        end else if (load) begin
            acc     <= '0;
            carries <= '0;
        end else if (accept) begin
            acc     <= acc_nxt_sum;
            carries <= carries + COUNT_WIDTH'(add_cout);
        end
    end

    assign add_a           = acc;
    assign add_b           = bus.in_data;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_sum     = acc;
    assign bus.out_carries = carries;

endmodule : adder_accumulator

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator with a behavioural 16-bit adder in
// the feedback loop.
module tb_adder_accumulator;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] length;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_result;
    logic          add_cout;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    adder_acc_if #(.WIDTH(W), .COUNT_WIDTH(CW)) bus ();

    adder_accumulator #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .length     (length),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_cout   (add_cout),
        .busy       (busy),
        .bus        (bus.slave)
    );

    assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CW-1:0] len);
        start  = 1'b1;
        length = len;
        step();
        start  = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b1;
        start         = 1'b0;
        length        = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_carries", 32'(bus.out_carries), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Operands offered while idle are not consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0055;
        #1;
        chk("idle_add_b", 32'(add_b), 32'h0055);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;

        // Run 1: 1+2+3 back to back.
        start_run(8'd3);
        chk("r1_in_ready", 32'(bus.in_ready), 32'd1);
        chk("r1_busy", 32'(busy), 32'd1);
        chk("r1_acc0", 32'(add_a), 32'd0);
        send(16'h0001);
        chk("r1_add_a", 32'(add_a), 32'h0001);
        send(16'h0002);
        chk("r1_pre_last_valid", 32'(bus.out_valid), 32'd0);
        send(16'h0003);
        chk("r1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r1_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("r1_sum", 32'(bus.out_sum), 32'h0006);
        chk("r1_carries", 32'(bus.out_carries), 32'd0);
        take_result();
        chk("r1_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("r1_idle_busy", 32'(busy), 32'd0);

        // Run 2: carry out of the top bit.
        start_run(8'd2);
        send(16'hFFFF);
        send(16'h0002);
        chk("r2_out_valid", 32'(bus.out_valid), 32'd1);
`ifdef ADDACC_SATURATE_EN
        chk("r2_sum", 32'(bus.out_sum), 32'hFFFF);
`else
        chk("r2_sum", 32'(bus.out_sum), 32'h0001);
`endif
        chk("r2_carries", 32'(bus.out_carries), 32'd1);
        take_result();

        // Run 3: zero-length run goes straight to the result.
        start_run(8'd0);
        chk("r3_in_ready", 32'(bus.in_ready), 32'd0);
        chk("r3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r3_sum", 32'(bus.out_sum), 32'd0);
        chk("r3_carries", 32'(bus.out_carries), 32'd0);
        take_result();

        // Run 4: two-cycle bubbles before each operand, then backpressure.
        start_run(8'd4);
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 16'hDEAD;
            step();
            chk("r4_gap_ready", 32'(bus.in_ready), 32'd1);
            step();
            chk("r4_gap_hold", 32'(add_a), 32'(16'h0010 * ((i - 1) * i / 2)));
            send(16'(16'h0010 * i));
        end
        chk("r4_out_valid", 32'(bus.out_valid), 32'd1);
        start  = 1'b1;
        length = 8'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r4_bp_valid", 32'(bus.out_valid), 32'd1);
            chk("r4_bp_sum", 32'(bus.out_sum), 32'h00A0);
        end
        start = 1'b0;
        chk("r4_carries", 32'(bus.out_carries), 32'd0);
        take_result();
        chk("r4_start_ignored", 32'(busy), 32'd0);
        chk("r4_no_ready", 32'(bus.in_ready), 32'd0);

        // Asynchronous reset in the middle of a run.
        start_run(8'd3);
        send(16'h1234);
        chk("r5_add_a", 32'(add_a), 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("r5_rst_sum", 32'(bus.out_sum), 32'd0);
        chk("r5_rst_ready", 32'(bus.in_ready), 32'd0);
        chk("r5_rst_busy", 32'(busy), 32'd0);
        chk("r5_rst_add_a", 32'(add_a), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        start_run(8'd1);
        send(16'h0005);
        chk("r5_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r5_sum", 32'(bus.out_sum), 32'h0005);
        take_result();

        // Back-to-back runs: start held through the output handshake.
        start_run(8'd1);
        send(16'h00AA);
        chk("r6a_sum", 32'(bus.out_sum), 32'h00AA);
        start         = 1'b1;
        length        = 8'd1;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("r6_idle_gap", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        chk("r6b_in_ready", 32'(bus.in_ready), 32'd1);
        chk("r6b_acc_clear", 32'(add_a), 32'd0);
        send(16'h0011);
        chk("r6b_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r6b_sum", 32'(bus.out_sum), 32'h0011);
        chk("r6b_carries", 32'(bus.out_carries), 32'd0);
        take_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adder_accumulator

// File: doc/adder_accumulator.md
# adder_accumulator

Sequential accumulation controller wrapped around the team's combinational Width-bit adder. It accepts a stream of Length operands over a valid/ready handshake and drives the adder with (running sum, incoming operand). It captures the adder's Result/Cout each accepted beat and presents the final sum plus a carry count downstream over a second valid/ready handshake. It sits between the operand source and the result consumer, with the adder instance in its feedback loop.

## Interface
- Width, 16, operand/sum width; must match the attached adder.
- CountWidth, 8, width of Length and of the carry counter.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  begin a run; sampled only in IDLE.
- Length  in  CountWidth  number of operands in the run; latched with Start.
- InValid  in  1  operand valid.
- InReady  out  1  operand accepted when InValid && InReady.
- InData  in  Width  operand.
- AddA  out  Width  to adder A; always equals accumulator register.
- AddB  out  Width  to adder B; combinational copy of InData.
- AddResult  in  Width  from adder Result.
- AddCout  in  1  from adder Cout.
- OutValid  out  1  final result valid.
- OutReady  in  1  consumer accepts when OutValid && OutReady.
- OutSum  out  Width  accumulated sum.
- OutCarries  out  CountWidth  number of accepted beats that produced AddCout=1.
- Busy  out  1  high in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: InReady=0, OutValid=0. On Start=1: Acc<=0, Carries<=0, Remaining<=Length; go to ACCUM if Length!=0, else DONE.
- ACCUM: InReady=1. On accept: Acc<=AddResult, Carries<=Carries+AddCout, Remaining<=Remaining-1. Go to DONE when the accepted beat has Remaining==1. Without InValid, hold all state.
- DONE: OutValid=1, OutSum=Acc, OutCarries=Carries, all held stable until OutReady=1. Then go to IDLE.
- Start outside IDLE is ignored. InValid outside ACCUM is ignored; data is not consumed.
- Arithmetic: the sum wraps modulo 2^Width. Carries cannot overflow because at most Length carries occur and Length ≤ 2^CountWidth-1.
- Reset (any time, including mid-run): state=IDLE. Acc, Carries, Remaining, OutSum and OutCarries go to 0. InReady, OutValid and Busy go to 0. The partial run is discarded.

## Timing
- Start sampled at edge k; InReady=1 from cycle k+1.
- One operand per cycle maximum; adder path is combinational within the accept cycle (InData -> AddB -> AddResult -> Acc).
- OutValid rises the cycle after the last accept (1-cycle latency). For Length=0, it rises the cycle after Start.
- Result handshake completes in the OutReady cycle. IDLE follows next cycle, so a new Start is honoured no earlier than one cycle after the output handshake.
- InReady and OutValid are never high in the same cycle.

## Configuration
- ADDACC_SATURATE_EN defined: on an accepted beat with AddCout=1, Acc<=all ones instead of AddResult. The sum clamps at 2^Width-1. Carries still counts carry beats.
- Not defined: Acc<=AddResult (wrapping). OutCarries carries the overflow information.

## Structure
- Shared package/header adder_acc_pkg holds:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - default Width and CountWidth constants.
- One natural sub-module: adder_acc_ctrl.
  - Holds the FSM plus the Remaining down-counter.
  - Outputs InReady, OutValid, Busy and a load/accept strobe.
- The datapath registers (Acc, Carries) stay in the top.

## Test plan
- Length=3, InData 0x0001, 0x0002, 0x0003 back-to-back -> OutSum=0x0006, OutCarries=0. OutValid asserts exactly 1 cycle after the third accept.
- Length=2, InData 0xFFFF, 0x0002:
  - without macro -> OutSum=0x0001, OutCarries=1;
  - with ADDACC_SATURATE_EN -> OutSum=0xFFFF, OutCarries=1.
- Length=0 Start -> InReady never asserts. OutValid the next cycle with OutSum=0, OutCarries=0.
- Backpressure and bubbles, Length=4 with InValid gaps of 2 cycles:
  - gaps stall without state change;
  - OutReady held low 5 cycles keeps OutValid/OutSum stable;
  - Start pulses during DONE are ignored.
- Reset driven low mid-ACCUM after one accept of 0x1234 -> all outputs 0 asynchronously. After release, Start with Length=1, InData 0x0005 -> OutSum=0x0005.
- Consecutive runs: run A (Length=1, 0x00AA) immediately followed by Start for run B (Length=1, 0x0011) -> run B yields OutSum=0x0011; no residue from run A.
